// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode-side handshake.
// The master side is the fetch unit; the slave side is memory plus decode.
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [31:0]       out_instr;

    modport master (
        output imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, issues one imem request at a time, and drops stale responses.
// Define EXC_VECTOR_EN to add exc_req, a highest-priority redirect to 32'h8000_0180.
module if_fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
`ifdef EXC_VECTOR_EN
    input  logic              exc_req,
`endif
    if_fetch_unit_if.master   fbus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

`ifdef EXC_VECTOR_EN
    localparam logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(32'h8000_0180);
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, addr_q, out_pc_q;
    logic [31:0]       out_instr_q;
    logic              kill_q, req_vld_q, out_vld_q;

    logic              redir;
    logic [ADDR_W-1:0] tgt, pc_d, pc_inc;

    always_comb begin
        redir = 1'b0;
        tgt   = branch_target;
        case (pc_src)
            2'b01:   begin redir = 1'b1; tgt = branch_target; end
            2'b10:   begin redir = 1'b1; tgt = jump_target;   end
            default: ;
        endcase
`ifdef EXC_VECTOR_EN
        if (exc_req) begin
            redir = 1'b1;
            tgt   = EXC_VEC;
        end
`endif
    end

    assign pc_d   = redir ? tgt : pc_q;
    assign pc_inc = pc_q + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            kill_q      <= 1'b0;
            req_vld_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_instr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_q      <= pc_d;
                    addr_q    <= pc_d;
                    req_vld_q <= 1'b1;
                    state_q   <= REQ;
                end
                REQ: begin
                    // addr_q is frozen while pending; a redirect here makes the
                    // in-flight fetch stale, so mark its response for discard.
                    pc_q <= pc_d;
                    if (redir) kill_q <= 1'b1;
                    if (fbus.imem_req_ready) begin
                        req_vld_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    pc_q <= pc_d;
                    if (fbus.imem_rsp_valid && !kill_q && !redir) begin
                        out_instr_q <= fbus.imem_rsp_data;
                        out_pc_q    <= pc_q;
                        out_vld_q   <= 1'b1;
                        state_q     <= HOLD;
                    end else if (fbus.imem_rsp_valid) begin
                        kill_q    <= 1'b0;
                        addr_q    <= pc_d;
                        req_vld_q <= 1'b1;
                        state_q   <= REQ;
                    end else if (redir) begin
                        kill_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // A redirect wins over the sequential PC even if decode consumes this cycle.
                    if (redir || fbus.out_ready) begin
                        pc_q      <= redir ? tgt : pc_inc;
                        addr_q    <= redir ? tgt : pc_inc;
                        out_vld_q <= 1'b0;
                        req_vld_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fbus.imem_req_valid = req_vld_q;
    assign fbus.imem_addr      = addr_q;
    assign fbus.out_valid      = out_vld_q;
    assign fbus.out_pc         = out_pc_q;
    assign fbus.out_instr      = out_instr_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural instruction memory with programmable latency and an
// in-order scoreboard of expected (pc, instr) pairs checked at each decode handshake.
module tb_if_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target   = '0;
`ifdef EXC_VECTOR_EN
    logic        exc_req = 1'b0;
`endif

    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];
    exp_t e;

    if_fetch_unit_if #(.ADDR_W(32)) bus ();

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
`ifdef EXC_VECTOR_EN
        .exc_req       (exc_req),
`endif
        .fbus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc);
        return '{pc, mem_word(pc)};
    endfunction

    // Memory: accept seen at the negedge before an edge, answer lat cycles later.
    int          lat  = 1;
    int          pend = 0;
    logic [31:0] pend_addr = '0;
    logic        acc_n = 1'b0;
    logic [31:0] acc_addr_n = '0;

    always @(negedge clk) begin
        acc_n      = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr_n = bus.imem_addr;
    end

    always @(posedge clk) begin
        #1;
        bus.imem_rsp_valid = 1'b0;
        if (acc_n) begin
            pend      = lat;
            pend_addr = acc_addr_n;
            acc_n     = 1'b0;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend_addr);
            end
        end
    end

    // Scoreboard: every decode handshake must match the next expected fetch.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            nvec++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", bus.out_pc, bus.out_instr);
            end else begin
                e = sb.pop_front();
                if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                    nerr++;
                    $display("FAIL sb_handshake: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, e.pc, e.instr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_addr !== RST_PC || bus.out_valid !== 1'b0 ||
            bus.out_pc !== RST_PC || bus.out_instr !== 32'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got rv=%b addr=%h ov=%b pc=%h instr=%h, required 0/%h/0/%h/0",
                     bus.imem_req_valid, bus.imem_addr, bus.out_valid, bus.out_pc, bus.out_instr, RST_PC, RST_PC);
        end
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        step();
        step();
        nvec++;
        if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_held: got rv=%b ov=%b, required 0/0", bus.imem_req_valid, bus.out_valid);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) sb.push_back(mk(RST_PC + 32'(4 * i)));
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            nvec++;
            if (bus.out_valid !== ((k % 3) == 0)) begin
                nerr++;
                $display("FAIL stream_cadence: cycle %0d got out_valid=%b, required %b", k, bus.out_valid, (k % 3) == 0);
            end
            if (k == 1) begin
                nvec++;
                if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RST_PC) begin
                    nerr++;
                    $display("FAIL stream_first_req: got rv=%b addr=%h, required 1/%h", bus.imem_req_valid, bus.imem_addr, RST_PC);
                end
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== RST_PC + 32'hC ||
                bus.out_instr !== mem_word(RST_PC + 32'hC) || bus.imem_req_valid !== 1'b0) begin
                nerr++;
                $display("FAIL hold_stable: got ov=%b pc=%h instr=%h rv=%b, required 1/%h/%h/0",
                         bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_req_valid,
                         RST_PC + 32'hC, mem_word(RST_PC + 32'hC));
            end
        end
        bus.out_ready = 1'b1;
        step();
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RST_PC + 32'h10) begin
            nerr++;
            $display("FAIL hold_release: got rv=%b addr=%h, required 1/%h", bus.imem_req_valid, bus.imem_addr, RST_PC + 32'h10);
        end
    endtask

    task automatic test_branch_wait();
        lat = 2;
        step();
        pc_src        = 2'b01;
        branch_target = 32'h0000_0100;
        step();
        pc_src = 2'b00;
        nvec++;
        if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL branch_wait_kill: got rv=%b ov=%b, required 0/0", bus.imem_req_valid, bus.out_valid);
        end
        step();
        lat = 1;
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0000_0100 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL branch_redirect_req: got rv=%b addr=%h ov=%b, required 1/00000100/0",
                     bus.imem_req_valid, bus.imem_addr, bus.out_valid);
        end
        sb.push_back(mk(32'h0000_0100));
        step();
        step();
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0100) begin
            nerr++;
            $display("FAIL branch_out: got ov=%b pc=%h, required 1/00000100", bus.out_valid, bus.out_pc);
        end
        bus.imem_req_ready = 1'b0;
    endtask

    task automatic test_jump_req_stall();
        step();
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0000_0104) begin
            nerr++;
            $display("FAIL jump_stall_c1: got rv=%b addr=%h, required 1/00000104", bus.imem_req_valid, bus.imem_addr);
        end
        pc_src      = 2'b10;
        jump_target = 32'h0000_0200;
        step();
        pc_src = 2'b00;
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0000_0104) begin
                nerr++;
                $display("FAIL jump_stall_addr: got rv=%b addr=%h, required 1/00000104", bus.imem_req_valid, bus.imem_addr);
            end
            if (i == 0) step();
        end
        bus.imem_req_ready = 1'b1;
        step();
        step();
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0000_0200 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL jump_next_req: got rv=%b addr=%h ov=%b, required 1/00000200/0",
                     bus.imem_req_valid, bus.imem_addr, bus.out_valid);
        end
        sb.push_back(mk(32'h0000_0200));
        step();
        step();
    endtask

    task automatic test_hold_redirect_wrap();
        pc_src      = 2'b10;
        jump_target = 32'hFFFF_FFFC;
        step();
        pc_src = 2'b00;
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL hold_redirect: got rv=%b addr=%h ov=%b, required 1/fffffffc/0",
                     bus.imem_req_valid, bus.imem_addr, bus.out_valid);
        end
        sb.push_back(mk(32'hFFFF_FFFC));
        step();
        step();
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFFC) begin
            nerr++;
            $display("FAIL wrap_out: got ov=%b pc=%h, required 1/fffffffc", bus.out_valid, bus.out_pc);
        end
        step();
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0000_0000) begin
            nerr++;
            $display("FAIL wrap_req: got rv=%b addr=%h, required 1/00000000", bus.imem_req_valid, bus.imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        lat = 3;
        step();
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_addr !== RST_PC || bus.out_valid !== 1'b0 ||
            bus.out_pc !== RST_PC || bus.out_instr !== 32'h0) begin
            nerr++;
            $display("FAIL wait_reset: got rv=%b addr=%h ov=%b pc=%h instr=%h, required 0/%h/0/%h/0",
                     bus.imem_req_valid, bus.imem_addr, bus.out_valid, bus.out_pc, bus.out_instr, RST_PC, RST_PC);
        end
        step();
        rst_n = 1'b1;
        lat   = 1;
        sb.push_back(mk(RST_PC));
        step();
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RST_PC) begin
            nerr++;
            $display("FAIL post_reset_req: got rv=%b addr=%h, required 1/%h", bus.imem_req_valid, bus.imem_addr, RST_PC);
        end
        step();
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL late_rsp_ignored: got ov=%b, required 0", bus.out_valid);
        end
        step();
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== RST_PC || bus.out_instr !== mem_word(RST_PC)) begin
            nerr++;
            $display("FAIL post_reset_out: got ov=%b pc=%h instr=%h, required 1/%h/%h",
                     bus.out_valid, bus.out_pc, bus.out_instr, RST_PC, mem_word(RST_PC));
        end
    endtask

`ifdef EXC_VECTOR_EN
    task automatic test_exc_priority();
        exc_req       = 1'b1;
        pc_src        = 2'b01;
        branch_target = 32'h0000_0300;
        step();
        exc_req = 1'b0;
        pc_src  = 2'b00;
        nvec++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0180) begin
            nerr++;
            $display("FAIL exc_priority: got rv=%b addr=%h, required 1/80000180", bus.imem_req_valid, bus.imem_addr);
        end
    endtask
`endif

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        test_reset();
        test_stream();
        test_hold_stall();
        test_branch_wait();
        test_jump_req_stall();
        test_hold_redirect_wrap();
        test_reset_in_wait();
`ifdef EXC_VECTOR_EN
        test_exc_priority();
`else
        step();
`endif
        bus.out_ready = 1'b0;
        repeat (6) step();
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
